contador_bcd_scan: RTL and testbench

Multi-digit synchronous BCD up/down counter with built-in display scan multiplexing. It sits directly upstream of the BCD-to-7-segment decoder. Each cycle it presents one digit on `bcd` for the decoder, and a one-hot `digit_sel` that enables the matching display position. It also exports the full packed count for other logic.

---
 rtl/bcd_pkg.sv | 13 +
 rtl/bcd_digit.sv | 40 ++++
 rtl/contador_bcd_scan.sv | 109 ++++++++++
 tb/tb_contador_bcd_scan.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD constants and packed-width helper for the scanned counter.
// Used by contador_bcd_scan and bcd_digit.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [3:0] BCD_ZERO  = 4'd0;
  localparam logic [3:0] BCD_BLANK = 4'hF;

  function automatic int packed_w(input int n);
    return 4 * n;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single decade cell: clamped load, up/down step, carry/borrow out.
// carry_out fires when this cell steps across its 9/0 boundary.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_nib,
  output logic [3:0] nib,
  output logic       carry_out
);

  logic [3:0] nib_q, nib_d;

  always_comb begin
    nib_d = nib_q;
    if (load) begin
      nib_d = (load_nib > BCD_MAX) ? BCD_MAX : load_nib;
    end else if (step) begin
      if (up) begin
        nib_d = (nib_q == BCD_MAX) ? BCD_ZERO : nib_q + 4'd1;
      end else begin
        nib_d = (nib_q == BCD_ZERO) ? BCD_MAX : nib_q - 4'd1;
      end
    end
  end

  assign carry_out = step & ~load &
                     (up ? (nib_q == BCD_MAX) : (nib_q == BCD_ZERO));
  assign nib = nib_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) nib_q <= BCD_ZERO;
    else        nib_q <= nib_d;
  end

endmodule

// File: rtl/contador_bcd_scan.sv
// Multi-digit BCD up/down counter with display scan mux.
// Define CONTADOR_BCD_BLANK_LEADING_EN for leading-zero blanking on bcd.
module contador_bcd_scan
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          up,
  input  logic                          load,
  input  logic [packed_w(DIGITS)-1:0]   load_val,
  output logic [packed_w(DIGITS)-1:0]   value,
  output logic                          wrap,
  output logic [3:0]                    bcd,
  output logic [DIGITS-1:0]             digit_sel
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [3:0]    nibs [DIGITS];
  logic          wrap_q, wrap_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          term;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    logic st, co;
    if (i == 0) begin : g_first
      assign st = en & ~load;
    end else begin : g_next
      assign st = g_dig[i-1].co;
    end
    bcd_digit u_digit (
      .clk       (clk),
      .rst_n     (rst_n),
      .step      (st),
      .up        (up),
      .load      (load),
      .load_nib  (load_val[4*i +: 4]),
      .nib       (nibs[i]),
      .carry_out (co)
    );
  end

  always_comb begin
    value = '0;
    for (int i = 0; i < DIGITS; i++) begin
      value[4*i +: 4] = nibs[i];
    end
  end

  // Carry out of the top digit is exactly a full-range wrap.
  assign wrap_d = g_dig[DIGITS-1].co;
  assign wrap   = wrap_q;

  always_comb begin
    term    = (presc_q == PW'(SCAN_DIV - 1));
    presc_d = term ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (term) begin
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q  <= 1'b0;
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      wrap_q  <= wrap_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
    end
  end

  assign digit_sel = DIGITS'(1) << idx_q;

`ifdef CONTADOR_BCD_BLANK_LEADING_EN
  logic [DIGITS-1:0] blank;
  logic              hz;

  always_comb begin
    hz    = 1'b1;
    blank = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      hz       = hz & (nibs[i] == BCD_ZERO);
      blank[i] = hz & (i != 0);
    end
  end
`endif

  always_comb begin
    bcd = BCD_ZERO;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        bcd = nibs[i];
`ifdef CONTADOR_BCD_BLANK_LEADING_EN
        if (blank[i]) bcd = BCD_BLANK;
`endif
      end
    end
  end

endmodule

// File: tb/tb_contador_bcd_scan.sv
// Directed self-checking bench for contador_bcd_scan.
// Runs with DIGITS=4, SCAN_DIV=3.
module tb_contador_bcd_scan;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        up;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] value;
  logic        wrap;
  logic [3:0]  bcd;
  logic [3:0]  digit_sel;

  int n_chk;
  int n_pass;

  contador_bcd_scan #(
    .DIGITS   (4),
    .SCAN_DIV (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .up        (up),
    .load      (load),
    .load_val  (load_val),
    .value     (value),
    .wrap      (wrap),
    .bcd       (bcd),
    .digit_sel (digit_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load     = 1'b1;
    load_val = v;
    tick();
    load     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    n_chk++;
    if (value !== 16'h0000)
      $display("FAIL reset_value got=%h exp=0000", value);
    else n_pass++;
    n_chk++;
    if (wrap !== 1'b0)
      $display("FAIL reset_wrap got=%b exp=0", wrap);
    else n_pass++;
    n_chk++;
    if (digit_sel !== 4'b0001)
      $display("FAIL reset_sel got=%b exp=0001", digit_sel);
    else n_pass++;
    n_chk++;
    if (bcd !== 4'h0)
      $display("FAIL reset_bcd got=%h exp=0", bcd);
    else n_pass++;
  endtask

  task automatic test_up_wrap();
    do_load(16'h9998);
    en = 1'b1; up = 1'b1;
    tick();
    n_chk++;
    if (value !== 16'h9999 || wrap !== 1'b0)
      $display("FAIL up_step1 got=%h/%b exp=9999/0", value, wrap);
    else n_pass++;
    tick();
    en = 1'b0;
    n_chk++;
    if (value !== 16'h0000 || wrap !== 1'b1)
      $display("FAIL up_wrap got=%h/%b exp=0000/1", value, wrap);
    else n_pass++;
    tick();
    n_chk++;
    if (value !== 16'h0000 || wrap !== 1'b0)
      $display("FAIL up_hold got=%h/%b exp=0000/0", value, wrap);
    else n_pass++;
  endtask

  task automatic test_down_borrow();
    do_load(16'h1000);
    en = 1'b1; up = 1'b0;
    tick();
    n_chk++;
    if (value !== 16'h0999 || wrap !== 1'b0)
      $display("FAIL down_borrow got=%h/%b exp=0999/0", value, wrap);
    else n_pass++;
    repeat (998) tick();
    n_chk++;
    if (value !== 16'h0001 || wrap !== 1'b0)
      $display("FAIL down_run got=%h/%b exp=0001/0", value, wrap);
    else n_pass++;
    tick();
    n_chk++;
    if (value !== 16'h0000 || wrap !== 1'b0)
      $display("FAIL down_zero got=%h/%b exp=0000/0", value, wrap);
    else n_pass++;
    tick();
    n_chk++;
    if (value !== 16'h9999 || wrap !== 1'b1)
      $display("FAIL down_wrap got=%h/%b exp=9999/1", value, wrap);
    else n_pass++;
    tick();
    en = 1'b0;
    n_chk++;
    if (value !== 16'h9998 || wrap !== 1'b0)
      $display("FAIL down_after got=%h/%b exp=9998/0", value, wrap);
    else n_pass++;
  endtask

  task automatic test_load_clamp();
    do_load(16'h9999);
    en = 1'b1; up = 1'b1; load = 1'b1;
    load_val = 16'hA3F5;
    tick();
    load = 1'b0; en = 1'b0;
    n_chk++;
    if (value !== 16'h9395 || wrap !== 1'b0)
      $display("FAIL load_clamp got=%h/%b exp=9395/0", value, wrap);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_load(16'h0001);
    en = 1'b1; up = 1'b0;
    tick();
    tick();
    n_chk++;
    if (value !== 16'h9999 || wrap !== 1'b1)
      $display("FAIL b2b_wrap1 got=%h/%b exp=9999/1", value, wrap);
    else n_pass++;
    up = 1'b1;
    tick();
    en = 1'b0;
    n_chk++;
    if (value !== 16'h0000 || wrap !== 1'b1)
      $display("FAIL b2b_wrap2 got=%h/%b exp=0000/1", value, wrap);
    else n_pass++;
  endtask

  task automatic scan_start(input logic [15:0] v);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    en = 1'b0; load = 1'b1; load_val = v;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_scan(input logic [15:0] v,
                           input logic [15:0] exp_bcd);
    logic [3:0] eb;
    logic [3:0] es;
    int         ix;
    scan_start(v);
    for (int k = 1; k <= 12; k++) begin
      tick();
      load = 1'b0;
      ix = (k / 3) % 4;
      es = 4'b0001 << ix;
      eb = exp_bcd[4*ix +: 4];
      n_chk++;
      if (digit_sel !== es || bcd !== eb)
        $display("FAIL scan_%h_k%0d got=%b/%h exp=%b/%h",
                 v, k, digit_sel, bcd, es, eb);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    scan_start(16'h1234);
    repeat (6) tick();
    load = 1'b0;
    n_chk++;
    if (digit_sel !== 4'b0100 || bcd !== 4'h2)
      $display("FAIL arst_pre got=%b/%h exp=0100/2", digit_sel, bcd);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (digit_sel !== 4'b0001 || value !== 16'h0000 ||
        bcd !== 4'h0 || wrap !== 1'b0)
      $display("FAIL arst_clear got=%b/%h/%h exp=0001/0000/0",
               digit_sel, value, bcd);
    else n_pass++;
    #1;
    rst_n = 1'b1;
    en = 1'b1; up = 1'b1;
    tick();
    en = 1'b0;
    n_chk++;
    if (value !== 16'h0001)
      $display("FAIL arst_resume got=%h exp=0001", value);
    else n_pass++;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_up_wrap();
    test_down_borrow();
    test_load_clamp();
    test_back_to_back();
    test_scan(16'h1234, 16'h1234);
`ifdef CONTADOR_BCD_BLANK_LEADING_EN
    test_scan(16'h0007, 16'hFFF7);
`else
    test_scan(16'h0007, 16'h0007);
`endif
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
